timer_counter: RTL and testbench

Memory-mapped timer peripheral that answers the CPU's data-port stores and loads in the 0x7f00–0x7f0b window and produces the `TC0_int`/`TC1_int` hardware interrupt lines sampled by CP0. Two instances sit behind the system bridge, at base 0x7f00 and 0x7f10. Each holds CTRL, PRESET and COUNT registers and runs a four-state down-counter. When the count expires it raises an interrupt, either one-shot or auto-reload.

---
 rtl/timer_counter.sv | 181 ++++++++++++++++++
 tb/tb_timer_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter timer with interrupt output.
//
// Register window at BASE:
//   +0x0 CTRL   [3] IM, [2:1] Mode, [0] Enable (R/W)
//   +0x4 PRESET 32-bit reload value (R/W)
//   +0x8 COUNT  current count (read-only)
// Anything else in or outside the window reads 0 and ignores writes.
//
// Build option: define TIMER_AUTORELOAD_EN to make Mode 01 an auto-reload
// timer. Without it, Mode 01 behaves as one-shot and CTRL[2:1] always
// reads 00.
module timer_counter #(
   parameter logic [31:0] BASE = 32'h0000_7f00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StCnt,
      StInt
   } state_e;

   // Word addresses of the three registers.
   localparam logic [29:0] CtrlWord   = BASE[31:2];
   localparam logic [29:0] PresetWord = BASE[31:2] + 30'd1;
   localparam logic [29:0] CountWord  = BASE[31:2] + 30'd2;

   state_e      state_q, state_d;
   logic        ctrl_im_q, ctrl_im_d;
   logic [1:0]  ctrl_mode_q, ctrl_mode_d;
   logic        ctrl_en_q, ctrl_en_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        irq_flag_q, irq_flag_d;

   logic        sel_ctrl, sel_preset, sel_count;
   logic        wr_ctrl, wr_preset;
   logic        reload_mode;
   logic [1:0]  mode_wdata;
   logic        fsm_flag_set, fsm_flag_clr, fsm_en_clr;

   // Byte-offset bits never matter: only full-word stores reach this block.
   logic        unused_addr;
   assign unused_addr = ^addr[1:0];

   // Address decode and write strobes.
   always_comb begin
      sel_ctrl   = (addr[31:2] == CtrlWord);
      sel_preset = (addr[31:2] == PresetWord);
      sel_count  = (addr[31:2] == CountWord);
      wr_ctrl    = we & sel_ctrl;
      wr_preset  = we & sel_preset;
   end

`ifdef TIMER_AUTORELOAD_EN
   assign reload_mode = (ctrl_mode_q == 2'b01);
   assign mode_wdata  = wdata[2:1];
`else
   // Mode is held at one-shot.
   assign reload_mode = 1'b0;
   assign mode_wdata  = 2'b00;
`endif

   // Counter FSM: next state, count update and FSM-side flag/enable events.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      fsm_flag_set = 1'b0;
      fsm_flag_clr = 1'b0;
      fsm_en_clr   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ctrl_en_q) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            count_d      = preset_q;
            fsm_flag_clr = 1'b1;
            state_d      = StCnt;
         end
         StCnt: begin
            if (!ctrl_en_q) begin
               // Disabled mid-count: freeze COUNT where it is.
               state_d = StIdle;
            end else if (count_q <= 32'd1) begin
               // Covers PRESET=0 too, so COUNT never wraps.
               count_d      = 32'd0;
               fsm_flag_set = 1'b1;
               state_d      = StInt;
            end else begin
               count_d = count_q - 32'd1;
            end
         end
         StInt: begin
            if (reload_mode) begin
               // Enable stays set, so IDLE goes straight back to LOAD.
               fsm_flag_clr = 1'b1;
            end else begin
               fsm_en_clr = 1'b1;
            end
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Register file next state; a CPU write to CTRL overrides the FSM enable clear.
   always_comb begin
      ctrl_im_d   = ctrl_im_q;
      ctrl_mode_d = ctrl_mode_q;
      ctrl_en_d   = ctrl_en_q & ~fsm_en_clr;
      preset_d    = preset_q;
      if (wr_ctrl) begin
         ctrl_im_d   = wdata[3];
         ctrl_mode_d = mode_wdata;
         ctrl_en_d   = wdata[0];
      end
      if (wr_preset) begin
         preset_d = wdata;
      end
   end

   // Interrupt flag: a set from the FSM beats any clear on the same edge.
   always_comb begin
      irq_flag_d = irq_flag_q;
      if (fsm_flag_clr || wr_ctrl || wr_preset) begin
         irq_flag_d = 1'b0;
      end
      if (fsm_flag_set) begin
         irq_flag_d = 1'b1;
      end
   end

   // State and register storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         ctrl_im_q   <= 1'b0;
         ctrl_mode_q <= 2'b00;
         ctrl_en_q   <= 1'b0;
         preset_q    <= 32'd0;
         count_q     <= 32'd0;
         irq_flag_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctrl_im_q   <= ctrl_im_d;
         ctrl_mode_q <= ctrl_mode_d;
         ctrl_en_q   <= ctrl_en_d;
         preset_q    <= preset_d;
         count_q     <= count_d;
         irq_flag_q  <= irq_flag_d;
      end
   end

   // Zero-latency read mux over the current register values.
   always_comb begin
      rdata = 32'd0;
      if (sel_ctrl) begin
         rdata = {28'd0, ctrl_im_q, ctrl_mode_q, ctrl_en_q};
      end else if (sel_preset) begin
         rdata = preset_q;
      end else if (sel_count) begin
         rdata = count_q;
      end
   end

   // Mask is applied combinationally so IM changes show up at once.
   assign irq = ctrl_im_q & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter.
module tb_timer_counter;

   localparam logic [31:0] BASE = 32'h0000_7f00;

   logic        clk;
   logic        reset;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int total = 0;
   int bad   = 0;

   timer_counter #(
      .BASE(BASE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .we   (we),
      .addr (addr),
      .wdata(wdata),
      .rdata(rdata),
      .irq  (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Store that lands on the next rising edge; returns at the following falling edge.
   task automatic wr(input logic [31:0] off, input logic [31:0] data);
      we    = 1'b1;
      addr  = BASE + off;
      wdata = data;
      @(negedge clk);
      we    = 1'b0;
      wdata = 32'd0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
      addr = BASE + off;
      #1;
      total++;
      assert (rdata === exp) else begin
         bad++;
         $error("FAIL %s: rdata=%h expected=%h", tag, rdata, exp);
      end
   endtask

   task automatic chk_irq(input string tag, input logic exp);
      total++;
      assert (irq === exp) else begin
         bad++;
         $error("FAIL %s: irq=%b expected=%b", tag, irq, exp);
      end
   endtask

   initial begin
      logic [31:0] mode_ctrl;
      logic        exp_irq;
      reset = 1'b0;
      we    = 1'b0;
      addr  = 32'd0;
      wdata = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Reset state
      rd("rst_ctrl", 32'h0, 32'd0);
      rd("rst_preset", 32'h4, 32'd0);
      rd("rst_count", 32'h8, 32'd0);
      chk_irq("rst_irq", 1'b0);
      tick();
      rd("idle_count", 32'h8, 32'd0);

      // One-shot, PRESET=5: COUNT 5..0, irq after edge E7
      wr(32'h4, 32'd5);
      rd("os_preset", 32'h4, 32'd5);
      wr(32'h0, 32'h9);                     // E0
      rd("os_ctrl", 32'h0, 32'h9);
      tick();                               // E1: LOAD
      rd("os_load_count", 32'h8, 32'd0);
      tick();                               // E2
      rd("os_count_p", 32'h8, 32'd5);
      chk_irq("os_irq_e2", 1'b0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         rd("os_count", 32'h8, 32'd5 - 32'(k));
         chk_irq("os_irq", (k == 5));
      end
      tick();                               // E8: INT -> IDLE, Enable cleared
      rd("os_ctrl_done", 32'h0, 32'h8);
      chk_irq("os_irq_hold", 1'b1);
      tick();
      tick();
      chk_irq("os_irq_hold2", 1'b1);
      rd("os_count_zero", 32'h8, 32'd0);
      wr(32'h0, 32'h8);
      chk_irq("os_irq_cleared", 1'b0);
      rd("os_ctrl_after", 32'h0, 32'h8);

      // Mode 01, PRESET=3
      wr(32'h4, 32'd3);
      wr(32'h0, 32'hb);                     // E0
`ifdef TIMER_AUTORELOAD_EN
      mode_ctrl = 32'hb;
`else
      mode_ctrl = 32'h9;
`endif
      rd("ar_ctrl", 32'h0, mode_ctrl);
      for (int t = 1; t <= 24; t++) begin
         tick();
`ifdef TIMER_AUTORELOAD_EN
         exp_irq = (t >= 5) && (((t - 5) % 6) == 0);
`else
         exp_irq = (t >= 5);
`endif
         chk_irq("ar_irq", exp_irq);
      end
      wr(32'h0, 32'h0);
      repeat (3) tick();
      chk_irq("ar_stopped_irq", 1'b0);
      rd("ar_stopped_ctrl", 32'h0, 32'h0);

      // Disable mid-count freezes COUNT, re-enable reloads
      wr(32'h4, 32'd10);
      wr(32'h0, 32'h9);                     // E0
      repeat (5) tick();                    // E5
      rd("dis_count7", 32'h8, 32'd7);
      wr(32'h0, 32'h8);                     // E6: count -> 6, Enable off
      rd("dis_count6", 32'h8, 32'd6);
      tick();                               // E7: CNT -> IDLE
      rd("dis_frozen", 32'h8, 32'd6);
      repeat (3) tick();
      rd("dis_frozen2", 32'h8, 32'd6);
      chk_irq("dis_irq", 1'b0);
      wr(32'h0, 32'h9);                     // F0
      tick();
      tick();                               // F2
      rd("reen_count", 32'h8, 32'd10);
      wr(32'h4, 32'd4);                     // F3: PRESET write in CNT
      rd("preset_in_cnt", 32'h8, 32'd9);
      wr(32'h0, 32'h0);                     // F4: count 8, Enable off
      tick();                               // F5: IDLE
      rd("preset_in_cnt_hold", 32'h8, 32'd8);
      wr(32'h0, 32'h9);                     // G0
      tick();
      tick();                               // G2: LOAD picked up new PRESET
      rd("preset_new_load", 32'h8, 32'd4);
      wr(32'h0, 32'h0);
      repeat (2) tick();

      // PRESET=0 expires right after LOAD
      wr(32'h4, 32'd0);
      wr(32'h0, 32'h9);                     // E0
      tick();
      tick();                               // E2
      chk_irq("p0_irq_e2", 1'b0);
      tick();                               // E3
      chk_irq("p0_irq_e3", 1'b1);
      wr(32'h8, 32'h55);
      rd("cnt_ro", 32'h8, 32'd0);
      chk_irq("cnt_wr_keeps_irq", 1'b1);
      wr(32'hc, 32'hffff_ffff);
      rd("hole_c", 32'hc, 32'd0);
      rd("hole_ctrl", 32'h0, 32'h8);
      rd("hole_preset", 32'h4, 32'd0);
      wr(32'h10, 32'h9);
      rd("outside", 32'h10, 32'd0);
      rd("outside_ctrl", 32'h0, 32'h8);
      wr(32'h0, 32'h0);
      chk_irq("p0_cleared", 1'b0);

      // Asynchronous reset mid-count
      wr(32'h4, 32'd6);
      wr(32'h0, 32'h9);                     // E0
      repeat (4) tick();                    // E4
      rd("mid_count4", 32'h8, 32'd4);
      chk_irq("mid_irq0", 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_irq("ar_rst_irq", 1'b0);
      rd("ar_rst_ctrl", 32'h0, 32'd0);
      rd("ar_rst_preset", 32'h4, 32'd0);
      rd("ar_rst_count", 32'h8, 32'd0);
      tick();
      reset = 1'b1;
      repeat (3) tick();
      rd("post_rst_count", 32'h8, 32'd0);
      chk_irq("post_rst_irq", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
